// File: rtl/scope_ctrl_n.sv
// Front-panel controller for an N-channel oscilloscope: synchronised active-low
// buttons step the cursors and per-channel settings once per update tick, saturating at limits.
module scope_ctrl_n #(
  parameter int NCH       = 2,
  parameter int CH_W      = 3,
  parameter int COORD_W   = 11,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int OFF_MAX   = 479,
  parameter int SHIFT_MAX = 11,
  parameter int RATE_MAX  = 25,
  parameter int TICK_DIV  = 524288,
  parameter int DEF_X1    = 32,
  parameter int DEF_X2    = 90,
  parameter int DEF_Y1    = 25,
  parameter int DEF_Y2    = 100,
  parameter int DEF_OFF   = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ctrl_en,
  input  logic [2:0]             mode,
  input  logic [CH_W-1:0]        chan_sel,
  input  logic [3:0]             butt,
  output logic [COORD_W-1:0]     cursor_x1,
  output logic [COORD_W-1:0]     cursor_x2,
  output logic [COORD_W-1:0]     cursor_y1,
  output logic [COORD_W-1:0]     cursor_y2,
  output logic [NCH*COORD_W-1:0] offset_flat,
  output logic [NCH*4-1:0]       shift_flat,
  output logic [NCH*5-1:0]       rate_flat,
  output logic [NCH-1:0]         hold,
  output logic                   tick
);

  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [COORD_W-1:0] L_X_MAX     = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] L_Y_MAX     = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] L_OFF_MAX   = COORD_W'(OFF_MAX);
  localparam logic [COORD_W-1:0] L_SHIFT_MAX = COORD_W'(SHIFT_MAX);
  localparam logic [COORD_W-1:0] L_RATE_MAX  = COORD_W'(RATE_MAX);

  typedef enum logic [2:0] {
    M_CURSOR_Y      = 3'd0,
    M_CURSOR_X      = 3'd1,
    M_CURSOR_Y_PAIR = 3'd2,
    M_CURSOR_X_PAIR = 3'd3,
    M_OFFSET        = 3'd4,
    M_SHIFT         = 3'd5,
    M_RATE          = 3'd6,
    M_HOLD          = 3'd7
  } mode_e;

  logic [3:0]         r_sync1, r_sync2;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_armed;
  logic [COORD_W-1:0] r_x1, r_x2, r_y1, r_y2;
  logic [COORD_W-1:0] w_x1, w_x2, w_y1, w_y2;
  logic [COORD_W-1:0] r_off   [NCH];
  logic [COORD_W-1:0] w_off   [NCH];
  logic [3:0]         r_shift [NCH];
  logic [3:0]         w_shift [NCH];
  logic [4:0]         r_rate  [NCH];
  logic [4:0]         w_rate  [NCH];
  logic [NCH-1:0]     r_hold, w_hold;

  logic [3:0] w_pressed;
  logic       w_any, w_sel_a, w_up, w_one_shot, w_upd, w_go;
  logic       w_pair_x_ok, w_pair_y_ok;
  mode_e      w_mode;

  // Compare before stepping so a value at either bound holds instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_step(input logic [COORD_W-1:0] v,
                                                  input logic [COORD_W-1:0] max,
                                                  input logic up);
    if (up) return (v < max) ? v + COORD_W'(1) : v;
    return (v != '0) ? v - COORD_W'(1) : v;
  endfunction

  assign tick      = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign w_mode    = mode_e'(mode);
  assign w_pressed = ~r_sync2;
  assign w_any     = |w_pressed;
  // The highest-priority pressed button decides the action: A pair above B pair, plus above minus.
  assign w_sel_a    = w_pressed[3] | w_pressed[2];
  assign w_up       = w_pressed[3] | (~w_pressed[2] & w_pressed[1]);
  assign w_one_shot = (w_mode == M_SHIFT) || (w_mode == M_RATE) || (w_mode == M_HOLD);
  assign w_upd      = tick & ctrl_en;
  assign w_go       = w_upd & w_any & (~w_one_shot | r_armed);

  assign w_pair_x_ok = w_up ? ((r_x1 < L_X_MAX) && (r_x2 < L_X_MAX))
                            : ((r_x1 != '0) && (r_x2 != '0));
  assign w_pair_y_ok = w_up ? ((r_y1 < L_Y_MAX) && (r_y2 < L_Y_MAX))
                            : ((r_y1 != '0) && (r_y2 != '0));

  // NOTE: every always_comb output is given its hold value first, so no path infers a latch.
  always_comb begin
    w_x1    = r_x1;
    w_x2    = r_x2;
    w_y1    = r_y1;
    w_y2    = r_y2;
    w_off   = r_off;
    w_shift = r_shift;
    w_rate  = r_rate;
    w_hold  = r_hold;
    if (w_go) begin
      case (w_mode)
        M_CURSOR_Y: begin
          if (w_sel_a) w_y1 = sat_step(r_y1, L_Y_MAX, w_up);
          else         w_y2 = sat_step(r_y2, L_Y_MAX, w_up);
        end
        M_CURSOR_X: begin
          if (w_sel_a) w_x1 = sat_step(r_x1, L_X_MAX, w_up);
          else         w_x2 = sat_step(r_x2, L_X_MAX, w_up);
        end
        M_CURSOR_Y_PAIR: begin
          if (w_sel_a && w_pair_y_ok) begin
            w_y1 = sat_step(r_y1, L_Y_MAX, w_up);
            w_y2 = sat_step(r_y2, L_Y_MAX, w_up);
          end
        end
        M_CURSOR_X_PAIR: begin
          if (w_sel_a && w_pair_x_ok) begin
            w_x1 = sat_step(r_x1, L_X_MAX, w_up);
            w_x2 = sat_step(r_x2, L_X_MAX, w_up);
          end
        end
        default: begin
          // An out-of-range chan_sel matches no channel, so the press does nothing.
          for (int i = 0; i < NCH; i++) begin
            if (w_sel_a && (chan_sel == CH_W'(i))) begin
              case (w_mode)
                M_OFFSET: w_off[i]   = sat_step(r_off[i], L_OFF_MAX, w_up);
                M_SHIFT:  w_shift[i] = 4'(sat_step(COORD_W'(r_shift[i]), L_SHIFT_MAX, w_up));
                M_RATE:   w_rate[i]  = 5'(sat_step(COORD_W'(r_rate[i]), L_RATE_MAX, w_up));
                M_HOLD:   w_hold[i]  = w_up;
                default:  ;
              endcase
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_cnt   <= '0;
      r_armed <= 1'b1;
      r_x1    <= COORD_W'(DEF_X1);
      r_x2    <= COORD_W'(DEF_X2);
      r_y1    <= COORD_W'(DEF_Y1);
      r_y2    <= COORD_W'(DEF_Y2);
      // NOTE: the per-channel arrays are user-visible settings, so each entry is reset explicitly.
      for (int i = 0; i < NCH; i++) begin
        r_off[i]   <= COORD_W'(DEF_OFF);
        r_shift[i] <= '0;
        r_rate[i]  <= '0;
      end
      r_hold  <= '0;
    end else begin
      r_sync1 <= butt;
      r_sync2 <= r_sync1;
      r_cnt   <= tick ? '0 : r_cnt + CNT_W'(1);
      // Any press disarms; only a tick with every button released re-arms.
      if (w_upd) r_armed <= ~w_any;
      r_x1    <= w_x1;
      r_x2    <= w_x2;
      r_y1    <= w_y1;
      r_y2    <= w_y2;
      r_off   <= w_off;
      r_shift <= w_shift;
      r_rate  <= w_rate;
      r_hold  <= w_hold;
    end
  end

  assign cursor_x1 = r_x1;
  assign cursor_x2 = r_x2;
  assign cursor_y1 = r_y1;
  assign cursor_y2 = r_y2;
  assign hold      = r_hold;

  for (genvar g = 0; g < NCH; g++) begin : g_flat
    assign offset_flat[g*COORD_W +: COORD_W] = r_off[g];
    assign shift_flat[g*4 +: 4]              = r_shift[g];
    assign rate_flat[g*5 +: 5]               = r_rate[g];
  end

endmodule

// File: doc/scope_ctrl_n.md
Name: scope_ctrl_n

Overview:
- Parametrised N-channel front-panel controller for the oscilloscope.
- Turns four active-low push buttons plus a mode/channel selection into registered display settings:
  - two X cursors and two Y cursors;
  - per-channel vertical offset, amplitude shift (squish), sample-rate select and hold.
- Sits between the board switches/buttons and the VGA, sample and clock-select logic.
- Adds clamping, one-shot/auto-repeat classes and N channels; no value ever wraps.

Parameters:
- NCH, 2, number of waveform channels (1..8).
- CH_W, 3, width of channel select.
- COORD_W, 11, width of cursor and offset values.
- X_MAX, 639, maximum X cursor value.
- Y_MAX, 479, maximum Y cursor value.
- OFF_MAX, 479, maximum channel offset.
- SHIFT_MAX, 11, maximum amplitude right-shift.
- RATE_MAX, 25, maximum sample-rate select index.
- TICK_DIV, 524288, clock cycles per update tick (>=2).
- DEF_X1, 32, reset value of cursor X1.
- DEF_X2, 90, reset value of cursor X2.
- DEF_Y1, 25, reset value of cursor Y1.
- DEF_Y2, 100, reset value of cursor Y2.
- DEF_OFF, 30, reset offset for every channel.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ctrl_en  in  1  1 = controls live; 0 = all settings frozen.
- mode  in  3  function select (see Behaviour).
- chan_sel  in  CH_W  target channel for per-channel modes.
- butt  in  4  push buttons, active-low, asynchronous to clock.
- cursor_x1, cursor_x2, cursor_y1, cursor_y2  out  COORD_W each  cursor positions.
- offset_flat  out  NCH*COORD_W  channel i at bits [i*COORD_W +: COORD_W].
- shift_flat  out  NCH*4  per-channel right-shift.
- rate_flat  out  NCH*5  per-channel sample clock index.
- hold  out  NCH  per-channel hold flags.
- tick  out  1  one-cycle update strobe (debug/visibility).

Behaviour:

Reset (synchronous, active-high):
- Cursors take DEF_X1/DEF_X2/DEF_Y1/DEF_Y2.
- Every offset = DEF_OFF; shift = 0; rate = 0; hold = 0.
- Tick counter = 0, tick = 0, armed = 1, synchroniser flops = 1 (released).
- Reset mid-press: after release of reset, a still-held button acts at the next tick, as a new press.

Input synchronisation and tick:
- butt passes through a 2-flop synchroniser; pressed when the synchronised bit is 0.
- The counter counts 0..TICK_DIV-1 and wraps.
- tick = 1 for exactly the cycle in which the counter = TICK_DIV-1.
- All setting updates occur only on tick cycles with ctrl_en = 1; the registered result is visible the following cycle.
- ctrl_en = 0 freezes settings and armed, but the counter keeps running.

Button priority:
- Only one button acts per tick, chosen as butt[3] > butt[2] > butt[1] > butt[0].
- butt[3] = A+, butt[2] = A-, butt[1] = B+, butt[0] = B-.

Modes:
- 0 CURSOR_Y: A adjusts Y1, B adjusts Y2. Auto-repeat.
- 1 CURSOR_X: A adjusts X1, B adjusts X2. Auto-repeat.
- 2 CURSOR_Y_PAIR: A+/A- move Y1 and Y2 together. Auto-repeat.
- 3 CURSOR_X_PAIR: A+/A- move X1 and X2 together. Auto-repeat.
- 4 OFFSET: A adjusts offset[chan_sel]. Auto-repeat.
- 5 SHIFT: A adjusts shift[chan_sel]. One-shot.
- 6 RATE: A adjusts rate[chan_sel]. One-shot.
- 7 HOLD: A+ sets hold[chan_sel]; A- clears it. One-shot.

Mode rules:
- Pair modes move both cursors only if both stay within range. If either would leave range, neither moves.
- In modes 4-7, B buttons are ignored; they still count as pressed for priority and for arming.
- chan_sel >= NCH: no action (the press still consumes the one-shot arm).

Auto-repeat: step of ±1 per tick while the button stays pressed.

One-shot:
- On a tick with armed = 1 and any button pressed, apply at most one step, then armed = 0.
- armed returns to 1 on the first tick where all four buttons are released.
- Changing mode or chan_sel while held does not re-arm.

Arithmetic:
- All increments/decrements saturate: lower bound 0, upper bound X_MAX / Y_MAX / OFF_MAX / SHIFT_MAX / RATE_MAX as applicable.
- Comparisons are unsigned and performed before the update, so no wrap is possible.
- Cursor 1 and cursor 2 are independent; no ordering is enforced between them.

Test Plan:
- TICK_DIV = 4 for all directed tests.
- Reset check: assert reset for 2 cycles -> X1 = 32, X2 = 90, Y1 = 25, Y2 = 100, every offset = 30, shift = 0, rate = 0, hold = 0, tick first high on cycle 4 after reset release.
- Auto-repeat: mode = 0, hold butt[3] = 0 for 5 ticks -> Y1 steps 26, 27, 28, 29, 30, one step per tick, each appearing the cycle after tick. Press butt[3] and butt[0] together -> only Y1 changes.
- Saturation: mode = 1, X2 forced to 639 via presses, keep butt[1] held -> X2 stays 639. Mode = 4, chan 1, offset 0, butt[2] held -> stays 0, no wrap to 2047.
- One-shot: mode = 5, chan_sel = 1, hold butt[3] for 10 ticks -> shift[1] = 1 only. Release for 1 tick, press again -> 2. Raise to 11, press again -> stays 11.
- Pair limit: mode = 3, X1 = 0, X2 = 90, butt[2] held -> neither moves. Mode = 2, butt[3] held -> Y1 and Y2 both increase by 1 per tick.
- Freeze and invalid channel: ctrl_en = 0 while butt[3] held in mode 4 -> offsets unchanged. Mode 7, chan_sel = 5 with NCH = 2, press butt[3] -> hold stays 00.
